pattern_scan_engine: RTL and testbench
======================================

Name: pattern_scan_engine

Overview:
- Hardware accelerator for the "where's Waldo" pattern-count workload, formerly run as software.
- Scans a contiguous region of data memory through a synchronous read port.
- Counts PAT_W-bit pattern occurrences inside each DATA_W-bit word, then raises done.
- Parametrised successor to the fixed 8-bit/4-bit, fixed-region software version: variable region, widths, and two count modes.

Parameters:
DATA_W, 8, width of each memory word scanned
PAT_W, 4, pattern width; must satisfy 1 <= PAT_W <= DATA_W
ADDR_W, 8, memory address width
CNT_W, 8, result counter width (saturating)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; launches a scan when idle
base_addr  in  ADDR_W  first word address, sampled on start
length  in  ADDR_W+1  number of words to scan (0..2^ADDR_W), sampled on start
pattern  in  PAT_W  pattern to match, sampled on start
mode  in  1  0 = count words with >=1 match; 1 = count every matching bit position; sampled on start
mem_rd  out  1  read strobe to data memory
mem_addr  out  ADDR_W  read address
mem_rdata  in  DATA_W  read data, valid exactly one cycle after mem_rd
count  out  CNT_W  match count; final value when done=1
busy  out  1  scan in progress
done  out  1  level; high from scan completion until next accepted start or reset

Behaviour:
- Reset values: mem_rd=0, mem_addr=0, count=0, busy=0, done=0; FSM in IDLE. Reset is async and overrides everything, including mid-scan: the scan is abandoned and no result is produced.
- FSM states: IDLE, READ, DRAIN, FIN.
- IDLE + start:
  - Latch base_addr, length, pattern, mode; clear count and done; set busy.
  - length==0: go to FIN, so done rises 1 cycle after start with count=0.
  - otherwise: go to READ.
- READ:
  - Each cycle: mem_rd=1, mem_addr=base+i, i=0..length-1.
  - Address arithmetic is modulo 2^ADDR_W, so the region wraps past the top of memory.
  - After the last address is issued, go to DRAIN.
- DRAIN: one cycle to accept the final read word; mem_rd=0; then FIN.
- Accumulation is pipelined, one word per cycle. Data arriving in cycle n+1 for the address issued in cycle n is evaluated that cycle.
- Match positions per word: k=0..DATA_W-PAT_W; position k matches when word[k+PAT_W-1:k]==pattern.
- Per-word increment:
  - mode 0: 1 if any position matches, else 0.
  - mode 1: number of matching positions (0..DATA_W-PAT_W+1).
- count adds the increment and saturates at 2^CNT_W-1; it never wraps.
- FIN: busy=0, done=1; go to IDLE. done stays high in IDLE.
- Latency: done asserts length+2 cycles after the start cycle for length>=1.
- start while busy=1 is ignored: no relatch, no restart.
- start in the same cycle done is high: accepted; done clears next cycle.
- mem_rdata is ignored whenever no read is outstanding.

Optional Feature:
FIRST_MATCH_EN
- Defined:
  - Adds outputs found (1 bit) and first_addr (ADDR_W bits), both cleared on reset and on an accepted start.
  - On the first word with a nonzero increment, first_addr is set to that word's address and found is set to 1.
  - Both hold their values until the next start or reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Stimulus: single word 0xDD at addr 32, pattern 4'b1101, length 1, mode 0 -> count=1, done at start+3 cycles. Same stimulus with mode 1 -> count=2 (positions 0 and 4).
- Stimulus: 64 random words at addr 32..95, pattern 4'b1101, mode 0 -> count equals the bench model (any-of-5-windows match per word); mem_rd is high for exactly 64 consecutive cycles.
- Stimulus: length 0 -> done 1 cycle after start, count=0, mem_rd never asserted. Separately, base 250, length 10 -> addresses 250..255 then 0..3.
- Stimulus: 256 words of 0xFF, pattern 4'b1111, mode 1, CNT_W=8 -> true value 1280, count saturates at 255. A second start with busy=1 mid-scan has no effect.
- Stimulus: reset asserted mid-scan at word 20 -> outputs return to reset values immediately (async). A subsequent start with a new region gives the correct count.
- Stimulus (FIRST_MATCH_EN): words 0x00,0x00,0x0D at addr 128..130, pattern 4'b1101 -> found=1, first_addr=130, count=1.

Source files
------------

// File: rtl/pattern_scan_engine_if.sv
// -----------------------------------------------------------------------------
// pattern_scan_engine_if
//   Synchronous read port between the pattern scan engine and data memory.
//
//   Signals:
//     mem_rd     read strobe, driven by the engine
//     mem_addr   read address, driven by the engine
//     mem_rdata  read data, returned by memory one cycle after mem_rd
//
//   Modports:
//     master  engine side (drives mem_rd/mem_addr, receives mem_rdata)
//     slave   memory side
// -----------------------------------------------------------------------------
interface pattern_scan_engine_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;

   modport master (output mem_rd, output mem_addr, input  mem_rdata);
   modport slave  (input  mem_rd, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/pattern_scan_engine.sv
// -----------------------------------------------------------------------------
// pattern_scan_engine
//   Scans length_i consecutive memory words starting at base_addr_i (address
//   wraps modulo 2^ADDR_W) and counts PAT_W-bit pattern occurrences in each
//   DATA_W-bit word. mode 0 counts words with at least one match, mode 1 counts
//   every matching bit position. The count saturates at 2^CNT_W-1.
//
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     start_i        one-cycle launch pulse, accepted only when not busy
//     base_addr_i    first word address        (sampled on start)
//     length_i       number of words, 0..2^ADDR_W (sampled on start)
//     pattern_i      pattern to match          (sampled on start)
//     mode_i         count mode                (sampled on start)
//     mem_if         memory read port (master modport)
//     count_o        match count, final while done_o=1
//     busy_o         scan in progress
//     done_o         level, high from completion until next accepted start
//
//   Optional feature (macro FIRST_MATCH_EN):
//     found_o        a word with a nonzero increment has been seen
//     first_addr_o   address of the first such word
// -----------------------------------------------------------------------------
module pattern_scan_engine #(
   parameter int DATA_W = 8,
   parameter int PAT_W  = 4,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [ADDR_W-1:0]     base_addr_i,
   input  logic [ADDR_W:0]       length_i,
   input  logic [PAT_W-1:0]      pattern_i,
   input  logic                  mode_i,
   pattern_scan_engine_if.master mem_if,
   output logic [CNT_W-1:0]      count_o,
   output logic                  busy_o,
   output logic                  done_o
`ifdef FIRST_MATCH_EN
   ,
   output logic                  found_o,
   output logic [ADDR_W-1:0]     first_addr_o
`endif
);

   localparam int NPOS  = DATA_W - PAT_W + 1;     // window positions per word
   localparam int INC_W = $clog2(NPOS + 1);       // holds 0..NPOS
   localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_e;

   state_e             state_q,   state_d;
   logic [ADDR_W-1:0]  addr_q,    addr_d;     // next address to issue
   logic [ADDR_W:0]    remain_q,  remain_d;   // addresses still to issue
   logic [PAT_W-1:0]   pattern_q, pattern_d;
   logic               mode_q,    mode_d;
   logic [CNT_W-1:0]   count_q,   count_d;
   logic               done_q,    done_d;
   logic               rd_pend_q, rd_pend_d;  // read issued last cycle
`ifdef FIRST_MATCH_EN
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;  // address of the pending read
   logic               found_q,   found_d;
   logic [ADDR_W-1:0]  first_q,   first_d;
`endif

   logic [NPOS-1:0]    match;
   logic [INC_W-1:0]   inc;
   logic [SUM_W-1:0]   sum;
   logic [CNT_W-1:0]   count_acc;

   // Per-position window compare on the returning word.
   always_comb begin
      match = '0;
      for (int k = 0; k < NPOS; k++) begin
         match[k] = (mem_if.mem_rdata[k +: PAT_W] == pattern_q);
      end
   end

   always_comb begin
      inc = '0;
      if (mode_q) begin
         for (int k = 0; k < NPOS; k++) begin
            inc = inc + INC_W'(match[k]);
         end
      end else begin
         inc = INC_W'(|match);
      end
   end

   // Widened add so the saturation test cannot itself overflow.
   assign sum       = SUM_W'(count_q) + SUM_W'(inc);
   assign count_acc = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];

   always_comb begin
      // NOTE: every signal written here gets a default first; a path that left
      // one unassigned would make synthesis infer a latch to hold it.
      state_d   = state_q;
      addr_d    = addr_q;
      remain_d  = remain_q;
      pattern_d = pattern_q;
      mode_d    = mode_q;
      count_d   = count_q;
      done_d    = done_q;
      rd_pend_d = 1'b0;
`ifdef FIRST_MATCH_EN
      rd_addr_d = rd_addr_q;
      found_d   = found_q;
      first_d   = first_q;
`endif

      // Word returned for the read issued last cycle; rdata is ignored otherwise.
      if (rd_pend_q) begin
         count_d = count_acc;
`ifdef FIRST_MATCH_EN
         if (!found_q && (inc != '0)) begin
            found_d = 1'b1;
            first_d = rd_addr_q;
         end
`endif
      end

      unique case (state_q)
         // FIN is not busy, so a start there is accepted just as in IDLE.
         S_IDLE, S_FIN: begin
            if (state_q == S_FIN) state_d = S_IDLE;
            if (start_i) begin
               addr_d    = base_addr_i;
               remain_d  = length_i;
               pattern_d = pattern_i;
               mode_d    = mode_i;
               count_d   = '0;
`ifdef FIRST_MATCH_EN
               found_d   = 1'b0;
               first_d   = '0;
`endif
               if (length_i == '0) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_READ;
                  done_d  = 1'b0;
               end
            end
         end
         S_READ: begin
            rd_pend_d = 1'b1;
`ifdef FIRST_MATCH_EN
            rd_addr_d = addr_q;
`endif
            addr_d    = addr_q + 1'b1;              // wraps modulo 2^ADDR_W
            remain_d  = remain_q - 1'b1;
            if (remain_q == (ADDR_W+1)'(1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            state_d = S_FIN;
            done_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         remain_q  <= '0;
         pattern_q <= '0;
         mode_q    <= 1'b0;
         count_q   <= '0;
         done_q    <= 1'b0;
         rd_pend_q <= 1'b0;
`ifdef FIRST_MATCH_EN
         rd_addr_q <= '0;
         found_q   <= 1'b0;
         first_q   <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // values present before the edge, independent of statement order.
         state_q   <= state_d;
         addr_q    <= addr_d;
         remain_q  <= remain_d;
         pattern_q <= pattern_d;
         mode_q    <= mode_d;
         count_q   <= count_d;
         done_q    <= done_d;
         rd_pend_q <= rd_pend_d;
`ifdef FIRST_MATCH_EN
         rd_addr_q <= rd_addr_d;
         found_q   <= found_d;
         first_q   <= first_d;
`endif
      end
   end

   assign mem_if.mem_rd   = (state_q == S_READ);
   assign mem_if.mem_addr = addr_q;
   assign count_o         = count_q;
   assign busy_o          = (state_q == S_READ) || (state_q == S_DRAIN);
   assign done_o          = done_q;
`ifdef FIRST_MATCH_EN
   assign found_o         = found_q;
   assign first_addr_o    = first_q;
`endif

endmodule

// File: tb/tb_pattern_scan_engine.sv
// -----------------------------------------------------------------------------
// tb_pattern_scan_engine
//   Self-checking bench for pattern_scan_engine (DATA_W=8, PAT_W=4, ADDR_W=8,
//   CNT_W=8). A behavioural memory answers reads one cycle later and returns
//   random junk when no read was issued. Each scan pushes its expected result
//   onto a scoreboard queue; the entry is popped and compared when done rises.
//   Define FIRST_MATCH_EN to also check found_o / first_addr_o.
// -----------------------------------------------------------------------------
module tb_pattern_scan_engine;

   logic       clk;
   logic       rst;
   logic       start_i;
   logic [7:0] base_addr_i;
   logic [8:0] length_i;
   logic [3:0] pattern_i;
   logic       mode_i;
   logic [7:0] count_o;
   logic       busy_o;
   logic       done_o;
`ifdef FIRST_MATCH_EN
   logic       found_o;
   logic [7:0] first_addr_o;
`endif

   pattern_scan_engine_if #(.DATA_W(8), .ADDR_W(8)) mem_if ();

   pattern_scan_engine #(.DATA_W(8), .PAT_W(4), .ADDR_W(8), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .base_addr_i (base_addr_i),
      .length_i    (length_i),
      .pattern_i   (pattern_i),
      .mode_i      (mode_i),
      .mem_if      (mem_if),
      .count_o     (count_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
`ifdef FIRST_MATCH_EN
      ,
      .found_o     (found_o),
      .first_addr_o(first_addr_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem_arr [256];

   always @(posedge clk) begin
      if (mem_if.mem_rd) mem_if.mem_rdata <= mem_arr[mem_if.mem_addr];
      else               mem_if.mem_rdata <= 8'($urandom);
   end

   typedef struct {
      logic [7:0] count;
      int         lat;
      logic       found;
      logic [7:0] first_addr;
   } exp_t;

   exp_t sb[$];
   logic [7:0] addr_log[$];
   int total = 0;
   int bad   = 0;

   // Reference: slide a 4-bit mask across each word, count hits.
   task automatic model_scan(input logic [7:0] base, input logic [8:0] len,
                             input logic [3:0] pat, input logic md,
                             output logic [7:0] cnt, output logic fnd,
                             output logic [7:0] fa);
      int acc;
      int hits;
      logic [7:0] a;
      logic [7:0] w;
      acc = 0;
      fnd = 1'b0;
      fa  = 8'h00;
      for (int i = 0; i < int'(len); i++) begin
         a = 8'(int'(base) + i);
         w = mem_arr[a];
         hits = 0;
         for (int k = 0; k <= 4; k++) begin
            if (((w >> k) & 8'h0F) == {4'h0, pat}) hits++;
         end
         if (hits > 0 && !fnd) begin
            fnd = 1'b1;
            fa  = a;
         end
         acc += md ? hits : ((hits > 0) ? 1 : 0);
      end
      cnt = (acc > 255) ? 8'hFF : 8'(acc);
   endtask

   // Launch one scan, monitor the read port, then pop and compare on done.
   // poke_at >= 2 fires a second start at that cycle, which must be ignored.
   task automatic run_scan(input string name, input logic [7:0] base,
                           input logic [8:0] len, input logic [3:0] pat,
                           input logic md, input int poke_at);
      exp_t e;
      exp_t g;
      int   cyc;
      int   rd_cnt;
      bit   seen_done;
      bit   gap;
      bit   rd_ended;
      bit   addr_ok;
      model_scan(base, len, pat, md, e.count, e.found, e.first_addr);
      e.lat = (len == 9'd0) ? 1 : int'(len) + 2;
      sb.push_back(e);
      addr_log.delete();
      base_addr_i = base;
      length_i    = len;
      pattern_i   = pat;
      mode_i      = md;
      start_i     = 1'b1;
      cyc = 0; rd_cnt = 0; seen_done = 0; gap = 0; rd_ended = 0;
      while (!seen_done && cyc < int'(len) + 20) begin
         @(negedge clk);
         cyc++;
         if (mem_if.mem_rd) begin
            addr_log.push_back(mem_if.mem_addr);
            rd_cnt++;
            if (rd_ended) gap = 1;
         end else if (rd_cnt > 0) begin
            rd_ended = 1;
         end
         if (cyc == 1 && len != 9'd0) begin
            total++;
            if (done_o !== 1'b0 || busy_o !== 1'b1) begin
               bad++;
               $display("FAIL %s after-start done/busy: got %b/%b want 0/1", name, done_o, busy_o);
            end
         end
         if (cyc == 1) start_i = 1'b0;
         if (cyc == poke_at) begin
            base_addr_i = 8'h10; length_i = 9'd5; pattern_i = 4'h0; mode_i = 1'b0;
            start_i = 1'b1;
         end else if (cyc == poke_at + 1) begin
            start_i = 1'b0;
         end
         if (done_o === 1'b1) seen_done = 1;
      end
      start_i = 1'b0;
      g = sb.pop_front();
      total++;
      if (!seen_done) begin
         bad++;
         $display("FAIL %s timeout: done not seen in %0d cycles", name, cyc);
         return;
      end
      if (count_o !== g.count) begin
         bad++;
         $display("FAIL %s count: got %0d want %0d", name, count_o, g.count);
      end
      total++;
      if (cyc !== g.lat) begin
         bad++;
         $display("FAIL %s latency: got %0d want %0d", name, cyc, g.lat);
      end
      total++;
      if (busy_o !== 1'b0) begin
         bad++;
         $display("FAIL %s busy at done: got %b want 0", name, busy_o);
      end
      total++;
      if (rd_cnt !== int'(len) || gap) begin
         bad++;
         $display("FAIL %s read strobe: got %0d cycles gap=%0d want %0d contiguous", name, rd_cnt, gap, len);
      end
      addr_ok = (addr_log.size() == int'(len));
      for (int i = 0; i < addr_log.size(); i++) begin
         if (addr_log[i] !== 8'(int'(base) + i)) addr_ok = 0;
      end
      total++;
      if (!addr_ok) begin
         bad++;
         $display("FAIL %s addresses: got %0d entries, first %0h want base %0h", name,
                  addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 8'h00, base);
      end
`ifdef FIRST_MATCH_EN
      total++;
      if (found_o !== g.found || (g.found && first_addr_o !== g.first_addr)) begin
         bad++;
         $display("FAIL %s first match: got %b/%0d want %b/%0d", name, found_o, first_addr_o,
                  g.found, g.first_addr);
      end
`endif
   endtask

   task automatic test_reset();
      total++;
      if (mem_if.mem_rd !== 1'b0 || mem_if.mem_addr !== 8'h00 || count_o !== 8'h00 ||
          busy_o !== 1'b0 || done_o !== 1'b0) begin
         bad++;
         $display("FAIL reset values: got rd=%b addr=%0h cnt=%0d busy=%b done=%b want all 0",
                  mem_if.mem_rd, mem_if.mem_addr, count_o, busy_o, done_o);
      end
   endtask

   task automatic test_single_word();
      mem_arr[32] = 8'hDD;
      run_scan("single_m0", 8'd32, 9'd1, 4'b1101, 1'b0, 0);
      run_scan("single_m1", 8'd32, 9'd1, 4'b1101, 1'b1, 0);
   endtask

   task automatic test_random_region();
      for (int i = 32; i < 96; i++) mem_arr[i] = 8'($urandom);
      mem_arr[40] = 8'hDD;
      run_scan("rand64_m0", 8'd32, 9'd64, 4'b1101, 1'b0, 0);
   endtask

   task automatic test_length_zero();
      run_scan("len0", 8'd77, 9'd0, 4'b1101, 1'b0, 0);
   endtask

   task automatic test_wrap();
      for (int i = 250; i < 256; i++) mem_arr[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) mem_arr[i] = 8'hB6;
      run_scan("wrap", 8'd250, 9'd10, 4'b0110, 1'b1, 0);
   endtask

   task automatic test_saturate_busy_start();
      for (int i = 0; i < 256; i++) mem_arr[i] = 8'hFF;
      run_scan("saturate", 8'd0, 9'd256, 4'b1111, 1'b1, 100);
   endtask

   task automatic test_reset_mid_scan();
      base_addr_i = 8'd0; length_i = 9'd100; pattern_i = 4'b1111; mode_i = 1'b1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (20) @(negedge clk);
      total++;
      if (busy_o !== 1'b1 || mem_if.mem_rd !== 1'b1) begin
         bad++;
         $display("FAIL midscan busy/rd: got %b/%b want 1/1", busy_o, mem_if.mem_rd);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (mem_if.mem_rd !== 1'b0 || mem_if.mem_addr !== 8'h00 || count_o !== 8'h00 ||
          busy_o !== 1'b0 || done_o !== 1'b0) begin
         bad++;
         $display("FAIL async reset: got rd=%b addr=%0h cnt=%0d busy=%b done=%b want all 0",
                  mem_if.mem_rd, mem_if.mem_addr, count_o, busy_o, done_o);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int i = 60; i < 72; i++) mem_arr[i] = 8'($urandom);
      mem_arr[61] = 8'h5A;
      run_scan("after_reset", 8'd60, 9'd12, 4'b1010, 1'b1, 0);
   endtask

   task automatic test_first_match();
      mem_arr[128] = 8'h00;
      mem_arr[129] = 8'h00;
      mem_arr[130] = 8'h0D;
      run_scan("first_match", 8'd128, 9'd3, 4'b1101, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 200; i < 220; i++) mem_arr[i] = 8'($urandom);
      run_scan("b2b_a", 8'd200, 9'd20, 4'b0011, 1'b1, 0);
      run_scan("b2b_b", 8'd205, 9'd7, 4'b0000, 1'b0, 0);
   endtask

   initial begin
      rst = 1'b1;
      start_i = 1'b0;
      base_addr_i = '0;
      length_i = '0;
      pattern_i = '0;
      mode_i = 1'b0;
      for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
      #12;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_length_zero();
      test_single_word();
      test_random_region();
      test_wrap();
      test_saturate_busy_start();
      test_reset_mid_scan();
      test_first_match();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
